mpu_alu_issue: RTL and testbench
================================

// Module: mpu_alu_issue
// PURPOSE
//  Driving end of the MPU ALU operand/result interface. Accepts one decoded-field
//  instruction per handshake, reads three operand registers from an internal
//  16x64 register file and drives size/op/operands/lane selectors to mpu_alu.
//  It then samples the ALU result, merges it into the selected lane of the
//  destination register, and signals completion. It sits between the MPU
//  sequencer (instruction source) and mpu_alu.
// PARAMETERS
//  NREG    16  number of 64-bit registers; index width is log2(NREG)=4
//  INSN_W  36  instruction word width
// PORTS
//  sys_clk     in   1   clock
//  sys_rst     in   1   reset, asynchronous, active-high
//  insn        in   36  [3:0]op [5:4]size [9:6]ra [13:10]rb [17:14]rc [21:18]rd
//                       [24:22]s0 [27:25]s1 [30:28]s2 [33:31]sres [35:34]rsvd
//  insn_valid  in   1   insn present
//  insn_ready  out  1   block can accept insn this cycle
//  done        out  1   1-cycle pulse, instruction retired (also on error)
//  err         out  1   1-cycle pulse with done, instruction rejected
//  host_we     in   1   host register write strobe
//  host_addr   in   4   host register index (write and read)
//  host_wdata  in   64  host write data
//  host_rdata  out  64  reg[host_addr], combinational read
//  host_err    out  1   1-cycle pulse, host write lost to a writeback collision
//  alu_size    out  2   to mpu_alu size
//  alu_op      out  4   to mpu_alu op
//  alu_o0/o1/o2 out 64  to mpu_alu operands (reg[ra], reg[rb], reg[rc])
//  alu_s0/s1/s2/alu_sres out 3  to mpu_alu lane selectors
//  alu_res     in   64  from mpu_alu, boolean already shifted to lane sres
// BEHAVIOUR
//  Reset: state IDLE; insn_ready=1; done=err=host_err=0; all alu_* outputs 0;
//   all registers 0. Reset mid-instruction aborts it: no writeback, no done.
//  FSM IDLE->OPER->EXEC->WB->IDLE. Handshake: accept when insn_valid&insn_ready;
//   insn_ready=1 only in IDLE. Accept cycle T latches fields.
//  Check at accept: op>3, rsvd!=0, or any of s0,s1,s2,sres >= (8>>size)
//   -> illegal; go straight to WB with err=1, no ALU drive, no register write.
//  OPER (T+1): alu_* registered from latched fields and reg[ra/rb/rc].
//  EXEC (T+2): alu_res is stable; compute bsize=8<<size, lsres=sres*bsize,
//   lane=(~(~64'b0<<bsize))<<lsres (bsize=64: lane=all ones);
//   nv=(reg[rd]&~lane)|(alu_res&lane); register nv.
//  WB (T+3): reg[rd]<=nv on the WB->IDLE edge; done=1. op=0 (nop): done,
//   no write. insn_ready rises at T+4; latency accept->done = 3 cycles,
//   throughput one insn per 4 cycles. alu_* outputs hold their last value.
//  Operands read in OPER; host writes after OPER do not affect current insn.
//  Host write in any state. Same-edge host write and WB to same register:
//   WB wins, host_err pulses next cycle. Different registers: both commit.
//  host_rdata reflects writes from the following cycle (no bypass).
//  All widths unsigned; shifts by >=64 produce 0.
// STRUCTURE
//  mpu_defs.vh: op codes (NOP=0, MASK=1, CMP=2, LT=3), insn field offsets,
//   state encodings; shared with the sequencer and mpu_alu.
//  Sub-module mpu_regfile: NREG x 64, async-reset, 3 read ports + host read,
//   1 write port with WB-priority arbitration and collision flag.
//  mpu_alu is instantiated by the parent, not inside this block.
// TESTING (bench instantiates mpu_alu alongside)
//  1 host r1=r2=64'hABCD, r3=64'hFFFF, r4=0; insn op=2 size=1 ra=1 rb=2 rc=3
//    rd=4 s*=0 sres=2 -> done at T+3, r4=64'h0000_0001_0000_0000.
//  2 r4=~0, r5=5, r6=7; op=3 size=0 ra=5 rb=6 sres=7 rd=4 -> r4=64'h01FF_FFFF_FFFF_FFFF;
//    with r5=9 -> r4=64'h00FF_FFFF_FFFF_FFFF.
//  3 op=2 size=3 s0=1 -> done&err at T+3, rd unchanged, insn_ready at T+4.
//  4 sys_rst asserted during EXEC -> all outputs 0 next edge, regs 0, no done.
//  5 host_we to rd on WB edge -> rd=ALU merge value, host_err=1 one cycle.
//  6 insn_valid held with two insns -> accepts at T and T+4, done at T+3, T+7.

Source files
------------

// File: rtl/mpu_alu_issue_pkg.sv
// +-----------------------------------------------------------------------+
// | mpu_alu_issue_pkg : shared types and helpers for the MPU ALU issue    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package mpu_alu_issue_pkg;

  localparam int DATA_W = 64;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MASK = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_LT   = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPER = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Instruction fields that survive the accept cycle (reserved bits dropped)
  typedef struct packed {
    logic [2:0] sres;
    logic [2:0] s2;
    logic [2:0] s1;
    logic [2:0] s0;
    logic [3:0] rd;
    logic [3:0] rc;
    logic [3:0] rb;
    logic [3:0] ra;
    logic [1:0] size;
    logic [3:0] op;
  } fields_t;

  typedef struct packed {
    logic [1:0] rsvd;
    fields_t    f;
  } insn_t;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] size,
                                                  input logic [2:0] sel);
    logic [6:0] bsize;
    logic [6:0] lsres;
    bsize = 7'd8 << size;
    lsres = 7'(sel) * bsize;
    if (size == 2'd3) begin
      return '1;
    end
    return ((64'd1 << bsize) - 64'd1) << lsres;
  endfunction

  // Lane selectors must address a lane that exists at this element size
  function automatic logic insn_illegal(input insn_t i);
    logic [3:0] nlanes;
    nlanes = 4'd8 >> i.f.size;
    return (i.f.op > OP_LT) || (i.rsvd != 2'd0) ||
           ({1'b0, i.f.s0}   >= nlanes) || ({1'b0, i.f.s1} >= nlanes) ||
           ({1'b0, i.f.s2}   >= nlanes) || ({1'b0, i.f.sres} >= nlanes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mpu_alu_issue_regfile.sv
// +-----------------------------------------------------------------------+
// | mpu_alu_issue_regfile : NREG x 64 register file, 3 read ports plus    |
// | host read, writeback/host write arbitration. Revision: 1.0            |
// +-----------------------------------------------------------------------+
`default_nettype none

module mpu_alu_issue_regfile #(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [63:0]   rd_data0,
  output logic [63:0]   rd_data1,
  output logic [63:0]   rd_data2,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [63:0]   wb_data,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [63:0]   host_wdata,
  output logic [63:0]   host_rdata,
  output logic          host_err
);

  logic [63:0] regs_q [NREG];
  logic [63:0] regs_d [NREG];
  logic        host_err_q, host_err_d;

  // Writeback is applied after the host write so it wins a same-index collision
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (host_we && (host_addr == AW'(i))) regs_d[i] = host_wdata;
      if (wb_we && (wb_addr == AW'(i)))     regs_d[i] = wb_data;
    end
    host_err_d = host_we && wb_we && (host_addr == wb_addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      host_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      host_err_q <= host_err_d;
    end
  end

  assign rd_data0   = regs_q[rd_addr0];
  assign rd_data1   = regs_q[rd_addr1];
  assign rd_data2   = regs_q[rd_addr2];
  assign host_rdata = regs_q[host_addr];
  assign host_err   = host_err_q;

endmodule

`default_nettype wire

// File: rtl/mpu_alu_issue.sv
// +-----------------------------------------------------------------------+
// | mpu_alu_issue : issues decoded instructions to mpu_alu and merges the |
// | boolean result into a lane of the destination register. Rev: 1.0      |
// +-----------------------------------------------------------------------+
`default_nettype none

module mpu_alu_issue
  import mpu_alu_issue_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int INSN_W = 36
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [INSN_W-1:0] insn,
  input  logic              insn_valid,
  output logic              insn_ready,
  output logic              done,
  output logic              err,
  input  logic              host_we,
  input  logic [3:0]        host_addr,
  input  logic [63:0]       host_wdata,
  output logic [63:0]       host_rdata,
  output logic              host_err,
  output logic [1:0]        alu_size,
  output logic [3:0]        alu_op,
  output logic [63:0]       alu_o0,
  output logic [63:0]       alu_o1,
  output logic [63:0]       alu_o2,
  output logic [2:0]        alu_s0,
  output logic [2:0]        alu_s1,
  output logic [2:0]        alu_s2,
  output logic [2:0]        alu_sres,
  input  logic [63:0]       alu_res
);

  state_e      state_q, state_d;
  fields_t     fld_q, fld_d;
  logic        bad_q, bad_d;
  logic [1:0]  alu_size_q, alu_size_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [63:0] alu_o0_q, alu_o0_d;
  logic [63:0] alu_o1_q, alu_o1_d;
  logic [63:0] alu_o2_q, alu_o2_d;
  logic [2:0]  alu_s0_q, alu_s0_d;
  logic [2:0]  alu_s1_q, alu_s1_d;
  logic [2:0]  alu_s2_q, alu_s2_d;
  logic [2:0]  alu_sres_q, alu_sres_d;
  logic [63:0] nv_q, nv_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  insn_t       insn_in;
  logic [3:0]  rf_addr0;
  logic [63:0] rf_data0, rf_data1, rf_data2;
  logic [63:0] lane;
  logic        wb_we;

  assign insn_in = insn_t'(insn);

  // Read port 0 doubles as the destination read while the result is merged
  assign rf_addr0 = (state_q == ST_EXEC) ? fld_q.rd : fld_q.ra;
  assign lane     = lane_mask(fld_q.size, fld_q.sres);
  assign wb_we    = (state_q == ST_WB) && !bad_q && (fld_q.op != OP_NOP);

  mpu_alu_issue_regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .rd_addr0   (rf_addr0),
    .rd_addr1   (fld_q.rb),
    .rd_addr2   (fld_q.rc),
    .rd_data0   (rf_data0),
    .rd_data1   (rf_data1),
    .rd_data2   (rf_data2),
    .wb_we      (wb_we),
    .wb_addr    (fld_q.rd),
    .wb_data    (nv_q),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_err   (host_err)
  );

  always_comb begin
    state_d    = state_q;
    fld_d      = fld_q;
    bad_d      = bad_q;
    alu_size_d = alu_size_q;
    alu_op_d   = alu_op_q;
    alu_o0_d   = alu_o0_q;
    alu_o1_d   = alu_o1_q;
    alu_o2_d   = alu_o2_q;
    alu_s0_d   = alu_s0_q;
    alu_s1_d   = alu_s1_q;
    alu_s2_d   = alu_s2_q;
    alu_sres_d = alu_sres_q;
    nv_d       = nv_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (insn_valid) begin
          fld_d   = insn_in.f;
          bad_d   = insn_illegal(insn_in);
          state_d = ST_OPER;
        end
      end
      ST_OPER: begin
        // Rejected instructions keep the ALU interface at its previous value
        if (!bad_q) begin
          alu_size_d = fld_q.size;
          alu_op_d   = fld_q.op;
          alu_o0_d   = rf_data0;
          alu_o1_d   = rf_data1;
          alu_o2_d   = rf_data2;
          alu_s0_d   = fld_q.s0;
          alu_s1_d   = fld_q.s1;
          alu_s2_d   = fld_q.s2;
          alu_sres_d = fld_q.sres;
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        nv_d    = (rf_data0 & ~lane) | (alu_res & lane);
        done_d  = 1'b1;
        err_d   = bad_q;
        state_d = ST_WB;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      fld_q      <= '0;
      bad_q      <= 1'b0;
      alu_size_q <= '0;
      alu_op_q   <= '0;
      alu_o0_q   <= '0;
      alu_o1_q   <= '0;
      alu_o2_q   <= '0;
      alu_s0_q   <= '0;
      alu_s1_q   <= '0;
      alu_s2_q   <= '0;
      alu_sres_q <= '0;
      nv_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fld_q      <= fld_d;
      bad_q      <= bad_d;
      alu_size_q <= alu_size_d;
      alu_op_q   <= alu_op_d;
      alu_o0_q   <= alu_o0_d;
      alu_o1_q   <= alu_o1_d;
      alu_o2_q   <= alu_o2_d;
      alu_s0_q   <= alu_s0_d;
      alu_s1_q   <= alu_s1_d;
      alu_s2_q   <= alu_s2_d;
      alu_sres_q <= alu_sres_d;
      nv_q       <= nv_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign insn_ready = (state_q == ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign alu_size   = alu_size_q;
  assign alu_op     = alu_op_q;
  assign alu_o0     = alu_o0_q;
  assign alu_o1     = alu_o1_q;
  assign alu_o2     = alu_o2_q;
  assign alu_s0     = alu_s0_q;
  assign alu_s1     = alu_s1_q;
  assign alu_s2     = alu_s2_q;
  assign alu_sres   = alu_sres_q;

endmodule

`default_nettype wire

// File: tb/tb_mpu_alu_issue.sv
// +-----------------------------------------------------------------------+
// | tb_mpu_alu_issue : directed vectors for mpu_alu_issue with a small    |
// | behavioural ALU partner. Revision: 1.0                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_mpu_alu_issue;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [35:0] insn;
  logic        insn_valid;
  logic        insn_ready;
  logic        done;
  logic        err;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [63:0] host_wdata;
  logic [63:0] host_rdata;
  logic        host_err;
  logic [1:0]  alu_size;
  logic [3:0]  alu_op;
  logic [63:0] alu_o0, alu_o1, alu_o2;
  logic [2:0]  alu_s0, alu_s1, alu_s2, alu_sres;
  logic [63:0] alu_res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  mpu_alu_issue #(
    .NREG   (16),
    .INSN_W (36)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .insn       (insn),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .done       (done),
    .err        (err),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_err   (host_err),
    .alu_size   (alu_size),
    .alu_op     (alu_op),
    .alu_o0     (alu_o0),
    .alu_o1     (alu_o1),
    .alu_o2     (alu_o2),
    .alu_s0     (alu_s0),
    .alu_s1     (alu_s1),
    .alu_s2     (alu_s2),
    .alu_sres   (alu_sres),
    .alu_res    (alu_res)
  );

  // Boolean ALU: MASK=(a&c)!=0, CMP=(a&c)==(b&c), LT=a<b; result placed in lane sres
  function automatic logic [63:0] alu_model(input logic [1:0] size, input logic [3:0] op,
                                            input logic [63:0] o0, o1, o2,
                                            input logic [2:0] s0, s1, s2, sres);
    int          bs;
    logic [63:0] m, a, b, c;
    logic        r;
    bs = 8 << size;
    m  = (bs == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bs) - 64'd1);
    a  = (o0 >> (s0 * bs)) & m;
    b  = (o1 >> (s1 * bs)) & m;
    c  = (o2 >> (s2 * bs)) & m;
    case (op)
      4'd1:    r = ((a & c) != 64'd0);
      4'd2:    r = ((a & c) == (b & c));
      4'd3:    r = (a < b);
      default: r = 1'b0;
    endcase
    return 64'(r) << (sres * bs);
  endfunction

  assign alu_res = alu_model(alu_size, alu_op, alu_o0, alu_o1, alu_o2,
                             alu_s0, alu_s1, alu_s2, alu_sres);

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  size;
    logic [3:0]  ra, rb, rc, rd;
    logic [2:0]  s0, s1, s2, sres;
    logic [1:0]  rsvd;
    logic [63:0] va, vb, vc, vd;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];
  vec_t vb_insn;

  function automatic logic [35:0] mk_insn(input vec_t v);
    return {v.rsvd, v.sres, v.s2, v.s1, v.s0, v.rd, v.rc, v.rb, v.ra, v.size, v.op};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [63:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic reg_chk(input string name, input logic [3:0] a, input logic [63:0] exp);
    host_addr = a;
    #1;
    chk(name, host_rdata, exp);
  endtask

  task automatic preload(input vec_t v);
    host_write(v.ra, v.va);
    host_write(v.rb, v.vb);
    host_write(v.rc, v.vc);
    host_write(v.rd, v.vd);
  endtask

  task automatic run_insn(input vec_t v, input string nm);
    chk({nm, " ready_idle"}, 64'(insn_ready), 64'd1);
    insn       = mk_insn(v);
    insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    insn       = '0;
    chk({nm, " ready_busy"}, 64'(insn_ready), 64'd0);
    chk({nm, " done_t1"}, 64'(done), 64'd0);
    tick();
    chk({nm, " done_t2"}, 64'(done), 64'd0);
    tick();
    chk({nm, " done_t3"}, 64'(done), 64'd1);
    chk({nm, " err_t3"}, 64'(err), 64'(v.exp_err));
    tick();
    chk({nm, " done_t4"}, 64'(done), 64'd0);
    chk({nm, " ready_t4"}, 64'(insn_ready), 64'd1);
    reg_chk({nm, " rd"}, v.rd, v.exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    //          op    sz    ra    rb    rc    rd    s0    s1    s2    sres  rsvd
    vecs[0]  = '{4'd2, 2'd1, 4'd1, 4'd2, 4'd3, 4'd4, 3'd0, 3'd0, 3'd0, 3'd2, 2'd0,
                 64'hABCD, 64'hABCD, 64'hFFFF, 64'h0, 64'h0000_0001_0000_0000, 1'b0};
    vecs[1]  = '{4'd3, 2'd0, 4'd5, 4'd6, 4'd7, 4'd4, 3'd0, 3'd0, 3'd0, 3'd7, 2'd0,
                 64'd5, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h01FF_FFFF_FFFF_FFFF, 1'b0};
    vecs[2]  = '{4'd3, 2'd0, 4'd5, 4'd6, 4'd7, 4'd4, 3'd0, 3'd0, 3'd0, 3'd7, 2'd0,
                 64'd9, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_FFFF_FFFF_FFFF, 1'b0};
    vecs[3]  = '{4'd2, 2'd2, 4'd1, 4'd2, 4'd3, 4'd8, 3'd1, 3'd0, 3'd0, 3'd1, 2'd0,
                 64'h1234_5678_0000_0000, 64'h1234_5679, 64'hFFFF_FFFF,
                 64'hAAAA_AAAA_BBBB_BBBB, 64'h0000_0000_BBBB_BBBB, 1'b0};
    vecs[4]  = '{4'd3, 2'd3, 4'd9, 4'd10, 4'd11, 4'd12, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0,
                 64'd3, 64'd4, 64'd0, 64'hDEAD, 64'h1, 1'b0};
    vecs[5]  = '{4'd0, 2'd0, 4'd1, 4'd2, 4'd3, 4'd13, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0,
                 64'd1, 64'd2, 64'd3, 64'h5555, 64'h5555, 1'b0};
    vecs[6]  = '{4'd2, 2'd3, 4'd1, 4'd2, 4'd3, 4'd14, 3'd1, 3'd0, 3'd0, 3'd0, 2'd0,
                 64'd1, 64'd1, 64'd1, 64'h7777, 64'h7777, 1'b1};
    vecs[7]  = '{4'd5, 2'd0, 4'd1, 4'd2, 4'd3, 4'd14, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0,
                 64'd1, 64'd1, 64'd1, 64'h7777, 64'h7777, 1'b1};
    vecs[8]  = '{4'd2, 2'd0, 4'd1, 4'd2, 4'd3, 4'd15, 3'd0, 3'd0, 3'd0, 3'd0, 2'd1,
                 64'd1, 64'd1, 64'd1, 64'h8888, 64'h8888, 1'b1};
    vecs[9]  = '{4'd2, 2'd1, 4'd1, 4'd2, 4'd3, 4'd15, 3'd0, 3'd0, 3'd0, 3'd4, 2'd0,
                 64'd1, 64'd1, 64'd1, 64'h9999, 64'h9999, 1'b1};
    vecs[10] = '{4'd2, 2'd1, 4'd1, 4'd2, 4'd3, 4'd4, 3'd0, 3'd0, 3'd0, 3'd3, 2'd0,
                 64'h42, 64'h42, 64'hFF, 64'h0, 64'h0001_0000_0000_0000, 1'b0};
    vecs[11] = '{4'd2, 2'd2, 4'd1, 4'd2, 4'd3, 4'd5, 3'd0, 3'd0, 3'd2, 3'd0, 2'd0,
                 64'd1, 64'd1, 64'd1, 64'h99, 64'h99, 1'b1};
    vb_insn  = '{4'd3, 2'd0, 4'd5, 4'd6, 4'd7, 4'd10, 3'd0, 3'd0, 3'd0, 3'd7, 2'd0,
                 64'd5, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h01FF_FFFF_FFFF_FFFF, 1'b0};

    sys_rst    = 1'b1;
    insn       = '0;
    insn_valid = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    tick();

    chk("rst insn_ready", 64'(insn_ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst host_err", 64'(host_err), 64'd0);
    chk("rst alu_op", 64'(alu_op), 64'd0);
    chk("rst alu_o0", alu_o0, 64'd0);
    chk("rst alu_sres", 64'(alu_sres), 64'd0);
    reg_chk("rst r4", 4'd4, 64'd0);
    reg_chk("rst r15", 4'd15, 64'd0);

    for (int i = 0; i < NV; i++) begin
      preload(vecs[i]);
      run_insn(vecs[i], $sformatf("v%0d", i));
    end

    // The final illegal vector must leave the last legal ALU drive in place
    chk("illegal keeps alu_op", 64'(alu_op), 64'd2);
    chk("illegal keeps alu_size", 64'(alu_size), 64'd1);
    chk("illegal keeps alu_sres", 64'(alu_sres), 64'd3);

    // Host write to rd on the writeback edge: writeback wins, host_err pulses
    preload(vecs[0]);
    insn = mk_insn(vecs[0]);
    insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    tick();
    chk("oper alu_o0", alu_o0, 64'hABCD);
    chk("oper alu_o2", alu_o2, 64'hFFFF);
    chk("oper alu_sres", 64'(alu_sres), 64'd2);
    tick();
    chk("coll done", 64'(done), 64'd1);
    host_we    = 1'b1;
    host_addr  = 4'd4;
    host_wdata = 64'h1234;
    tick();
    host_we = 1'b0;
    chk("coll host_err", 64'(host_err), 64'd1);
    reg_chk("coll r4", 4'd4, 64'h0000_0001_0000_0000);
    tick();
    chk("coll host_err clear", 64'(host_err), 64'd0);

    // Host write to a different register on the writeback edge: both commit
    preload(vecs[0]);
    insn = mk_insn(vecs[0]);
    insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    tick();
    tick();
    host_we    = 1'b1;
    host_addr  = 4'd9;
    host_wdata = 64'h5A;
    tick();
    host_we = 1'b0;
    chk("nocoll host_err", 64'(host_err), 64'd0);
    reg_chk("nocoll r9", 4'd9, 64'h5A);
    reg_chk("nocoll r4", 4'd4, 64'h0000_0001_0000_0000);

    // Back-to-back with insn_valid held: accepts at T and T+4
    preload(vecs[0]);
    host_write(4'd5, 64'd5);
    host_write(4'd6, 64'd7);
    host_write(4'd7, 64'd0);
    host_write(4'd10, 64'hFFFF_FFFF_FFFF_FFFF);
    insn = mk_insn(vecs[0]);
    insn_valid = 1'b1;
    tick();
    insn = mk_insn(vb_insn);
    tick();
    chk("b2b ready t1", 64'(insn_ready), 64'd0);
    tick();
    chk("b2b done A", 64'(done), 64'd1);
    tick();
    chk("b2b ready t4", 64'(insn_ready), 64'd1);
    chk("b2b done t4", 64'(done), 64'd0);
    tick();
    insn_valid = 1'b0;
    chk("b2b ready t5", 64'(insn_ready), 64'd0);
    tick();
    chk("b2b done t6", 64'(done), 64'd0);
    tick();
    chk("b2b done B", 64'(done), 64'd1);
    tick();
    reg_chk("b2b r4", 4'd4, 64'h0000_0001_0000_0000);
    reg_chk("b2b r10", 4'd10, 64'h01FF_FFFF_FFFF_FFFF);

    // Reset during EXEC aborts the instruction
    preload(vecs[0]);
    insn = mk_insn(vecs[0]);
    insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    tick();
    sys_rst = 1'b1;
    #1;
    chk("midrst alu_o0", alu_o0, 64'd0);
    chk("midrst alu_op", 64'(alu_op), 64'd0);
    chk("midrst ready", 64'(insn_ready), 64'd1);
    tick();
    sys_rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("midrst no done", 64'(seen_done), 64'd0);
    reg_chk("midrst r1", 4'd1, 64'd0);
    reg_chk("midrst r4", 4'd4, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
